// File: rtl/bitstream_pkg.sv
// bitstream_pkg: shared types for the stochastic bitstream blocks.
//   decoder_state_t : FSM encoding used by bitstream_decoder.
package bitstream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    VALID = 2'd2
  } decoder_state_t;

endpackage

// File: rtl/window_counter.sv
// window_counter: WIDTH-bit position counter inside a 2^WIDTH-cycle window.
// Ports:
//   clk, n_rst : clock, asynchronous active-low reset
//   clr        : synchronous clear to 0 (wins over en)
//   en         : advance by one; wraps naturally at 2^WIDTH
//   idx        : current position
//   last       : idx == 2^WIDTH - 1 (the edge now sampling the final bit)
module window_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] idx,
  output logic             last
);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      idx <= '0;
    end else if (clr) begin
      idx <= '0;
    end else if (en) begin
      idx <= idx + 1'b1;
    end
  end

  assign last = (idx == {WIDTH{1'b1}});

endmodule

// File: rtl/bitstream_decoder.sv
// bitstream_decoder: counts the 1s of a unipolar stochastic bitstream over a
// window of N = 2^WIDTH cycles and hands the count off on valid/ready.
// Ports:
//   clk, n_rst : clock, asynchronous active-low reset
//   x          : input bitstream, one bit per cycle
//   start      : request a window (taken in IDLE, or in VALID with a handshake)
//   clear      : synchronous abort to IDLE; value keeps its last result
//   busy       : high while the window is being sampled
//   value      : count of 1s in the last completed window (0..N)
//   valid      : value is new and not yet taken
//   ready      : consumer accepts value
//   dbg_state  : current FSM state (decoder_state_t encoding)
//
// Handshake: value is transferred on every rising edge where valid && ready
// are both high; value and valid hold stable until then, and ready while
// valid is low has no effect.
module bitstream_decoder
  import bitstream_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             x,
  input  logic             start,
  input  logic             clear,
  output logic             busy,
  output logic [WIDTH:0]   value,
  output logic             valid,
  input  logic             ready,
  output logic [1:0]       dbg_state
);

  decoder_state_t state;
  logic [WIDTH:0]   ones;
  logic [WIDTH-1:0] idx;
  logic             last;
  logic             take;
  logic             begin_win;
  logic [WIDTH:0]   ones_next;

  assign take      = (state == VALID) && valid && ready;
  assign begin_win = start && ((state == IDLE) || take);
  // Max count is N, which fits in WIDTH+1 bits, so no overflow here.
  assign ones_next = ones + {{WIDTH{1'b0}}, x};
  assign dbg_state = state;

  window_counter #(.WIDTH(WIDTH)) u_window_counter (
    .clk   (clk),
    .n_rst (n_rst),
    .clr   (clear || begin_win),
    .en    (state == ACCUM),
    .idx   (idx),
    .last  (last)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
      ones  <= '0;
      value <= '0;
      valid <= 1'b0;
      busy  <= 1'b0;
    end else if (clear) begin
      // Abort: value intentionally keeps the last completed result.
      state <= IDLE;
      ones  <= '0;
      valid <= 1'b0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= ACCUM;
            ones  <= '0;
            busy  <= 1'b1;
          end
        end
        ACCUM: begin
          // start is ignored here; the window always runs to completion.
          ones <= ones_next;
          if (last) begin
            value <= ones_next;
            valid <= 1'b1;
            busy  <= 1'b0;
            state <= VALID;
          end
        end
        VALID: begin
          if (take) begin
            valid <= 1'b0;
            if (start) begin
              // Back-to-back window: no IDLE cycle in between.
              state <= ACCUM;
              ones  <= '0;
              busy  <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bitstream_decoder.sv
// tb_bitstream_decoder: directed-vector bench for bitstream_decoder, WIDTH=4.
module tb_bitstream_decoder;
  import bitstream_pkg::*;

  localparam int WIDTH = 4;
  localparam int N     = 16;

  logic             clk;
  logic             n_rst;
  logic             x;
  logic             start;
  logic             clear;
  logic             busy;
  logic [WIDTH:0]   value;
  logic             valid;
  logic             ready;
  logic [1:0]       dbg_state;

  int errors = 0;
  int checks = 0;
  logic [WIDTH:0] exp_q[$];

  bitstream_decoder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .x         (x),
    .start     (start),
    .clear     (clear),
    .busy      (busy),
    .value     (value),
    .valid     (valid),
    .ready     (ready),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, act=running req=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: act=%0d req=%0d", name, act, req);
    end
  endtask

  // monitor: every accepted result is popped and compared
  always @(negedge clk) begin
    if (n_rst && valid && ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: act=%0d req=none", value);
      end else begin
        chk("result_value", 32'(value), 32'(exp_q.pop_front()));
      end
    end
  end

  // drivers (inputs change #1 after a rising edge)
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a window (edge 0) and feeds pat[i] for edge i+1. If mid_start is
  // 1..N, start is pulsed high on that edge of the window.
  task automatic run_window(input logic [N-1:0] pat, input logic [WIDTH:0] exp,
                            input int mid_start);
    start = 1'b1;
    exp_q.push_back(exp);
    tick();
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    for (int i = 0; i < N; i++) begin
      x     = pat[i];
      start = (mid_start == i + 1);
      tick();
      start = 1'b0;
    end
    x = 1'b0;
    chk("valid_after_edge_N", 32'(valid), 32'd1);
    chk("busy_after_edge_N", 32'(busy), 32'd0);
  endtask

  // Starts a window of 1s and stops driving just before edge n+1.
  task automatic partial_window(input int n);
    start = 1'b1;
    tick();
    start = 1'b0;
    x = 1'b1;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drain(input string name);
    int budget = 40;
    while (exp_q.size() != 0 && budget > 0) begin
      tick();
      budget--;
    end
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    n_rst = 1'b0;
    x     = 1'b0;
    start = 1'b0;
    clear = 1'b0;
    ready = 1'b0;
    repeat (2) tick();
    n_rst = 1'b1;
    tick();

    // reset state
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_value", 32'(value), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));

    // all ones, valid for exactly one cycle
    ready = 1'b1;
    run_window(16'hFFFF, 5'd16, 0);
    tick();
    chk("valid_one_cycle", 32'(valid), 32'd0);
    chk("idle_after_take", 32'(dbg_state), 32'(IDLE));

    // patterned streams
    run_window(16'h0FFF, 5'd12, 0);
    drain("drain_12");
    tick();
    run_window(16'h5555, 5'd8, 0);
    drain("drain_8");
    tick();
    run_window(16'h0000, 5'd0, 0);
    drain("drain_0");
    tick();

    // backpressure, then back-to-back window started on the handshake edge
    ready = 1'b0;
    run_window(16'h0007, 5'd3, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", 32'(valid), 32'd1);
      chk("bp_value", 32'(value), 32'd3);
    end
    ready = 1'b1;
    run_window(16'hFFFF, 5'd16, 0);
    drain("drain_b2b");
    tick();

    // start pulsed during ACCUM is ignored
    run_window(16'h00F0, 5'd4, 7);
    drain("drain_mid_start");
    tick();

    // clear mid-window keeps the previous value
    run_window(16'h001F, 5'd5, 0);
    drain("drain_5");
    tick();
    partial_window(8);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    x     = 1'b0;
    chk("clr_busy", 32'(busy), 32'd0);
    chk("clr_valid", 32'(valid), 32'd0);
    chk("clr_value", 32'(value), 32'd5);
    chk("clr_state", 32'(dbg_state), 32'(IDLE));
    tick();
    run_window(16'hFFFF, 5'd16, 0);
    drain("drain_after_clr");
    tick();

    // asynchronous reset mid-window
    partial_window(8);
    #2;
    n_rst = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_valid", 32'(valid), 32'd0);
    chk("arst_value", 32'(value), 32'd0);
    x = 1'b0;
    tick();
    n_rst = 1'b1;
    tick();
    run_window(16'hFFFF, 5'd16, 0);
    drain("drain_after_rst");
    ready = 1'b0;
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
